// File: rtl/hash_collector_pkg.sv
// Shared types and sizes for the hash digest collector.
package hash_collector_pkg;
  localparam int WORDS = 4;
  localparam int BYTES = 16;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAP    = 2'd1,
    STREAM = 2'd2
  } state_e;
endpackage

// File: rtl/hash_collector_if.sv
// Datapath/control/consumer signals of the hash collector; master drives, slave is the collector.
interface hash_collector_if;
  import hash_collector_pkg::*;

  word_t                data_in;
  logic                 data_out_valid;
  logic [8*BYTES-1:0]   expected;
  logic                 byte_ready;
  logic                 clr_err;
  logic [8*BYTES-1:0]   digest;
  logic                 digest_valid;
  logic                 match;
  logic [7:0]           byte_out;
  logic                 byte_valid;
  logic                 busy;
  logic                 err_short;
  logic                 err_overflow;

  modport master (
    output data_in, data_out_valid, expected, byte_ready, clr_err,
    input  digest, digest_valid, match, byte_out, byte_valid, busy, err_short, err_overflow
  );

  modport slave (
    input  data_in, data_out_valid, expected, byte_ready, clr_err,
    output digest, digest_valid, match, byte_out, byte_valid, busy, err_short, err_overflow
  );
endinterface

// File: rtl/hash_byte_ser.sv
// Streams the digest one byte per valid/ready handshake, LSB byte first; zero latency from active_i.
// Holds the current byte while byte_ready_i is low; last_o flags the handshake on the final byte.
module hash_byte_ser
  import hash_collector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               active_i,
  input  logic [8*BYTES-1:0] digest_i,
  input  logic               byte_ready_i,
  output logic [7:0]         byte_out_o,
  output logic               byte_valid_o,
  output logic               last_o
);
  logic [3:0] bcnt_q;
  logic [3:0] bcnt_d;
  logic       xfer;

  assign xfer         = active_i & byte_ready_i;
  assign last_o       = xfer && (bcnt_q == 4'(BYTES - 1));
  // Natural 4-bit wrap returns bcnt to 0 after the last byte.
  assign bcnt_d       = xfer ? bcnt_q + 4'd1 : bcnt_q;
  assign byte_valid_o = active_i;
  assign byte_out_o   = active_i ? digest_i[8*bcnt_q +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end
endmodule

// File: rtl/hash_collector.sv
// Captures a 4-word hash burst into a 128-bit digest, compares it with expected, then streams it bytewise.
// digest_valid/byte_valid rise the cycle after the 4th word; words arriving mid-stream are dropped and flagged.
module hash_collector
  import hash_collector_pkg::*;
(
  input logic             clk,
  input logic             rst,
  hash_collector_if.slave hc
);
  state_e             state_q;
  logic [1:0]         wcnt_q;
  word_t              words_q [WORDS];
  logic               match_q;
  logic               err_short_q;
  logic               err_ovf_q;
  logic               last_byte;
  logic               stream_act;
  logic [7:0]         ser_byte;
  logic               ser_valid;
  logic [8*BYTES-1:0] digest;

  assign digest     = {words_q[3], words_q[2], words_q[1], words_q[0]};
  assign stream_act = (state_q == STREAM);

  hash_byte_ser u_ser (
    .clk          (clk),
    .rst          (rst),
    .active_i     (stream_act),
    .digest_i     (digest),
    .byte_ready_i (hc.byte_ready),
    .byte_out_o   (ser_byte),
    .byte_valid_o (ser_valid),
    .last_o       (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      match_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
    end else begin
      // Clear first so an error event later in this block wins.
      if (hc.clr_err) begin
        err_short_q <= 1'b0;
        err_ovf_q   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (hc.data_out_valid) begin
            words_q[0] <= hc.data_in;
            wcnt_q     <= 2'd1;
            state_q    <= CAP;
          end
        end
        CAP: begin
          if (hc.data_out_valid) begin
            words_q[wcnt_q] <= hc.data_in;
            wcnt_q          <= wcnt_q + 2'd1;
            if (wcnt_q == 2'(WORDS - 1)) begin
              match_q <= ({hc.data_in, words_q[2], words_q[1], words_q[0]} == hc.expected);
              state_q <= STREAM;
            end
          end else begin
            err_short_q <= 1'b1;
            wcnt_q      <= '0;
            state_q     <= IDLE;
          end
        end
        STREAM: begin
          if (hc.data_out_valid) err_ovf_q <= 1'b1;
          if (last_byte) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hc.digest       = digest;
  assign hc.digest_valid = stream_act;
  assign hc.match        = match_q;
  assign hc.byte_out     = ser_byte;
  assign hc.byte_valid   = ser_valid;
  assign hc.busy         = (state_q != IDLE);
  assign hc.err_short    = err_short_q;
  assign hc.err_overflow = err_ovf_q;
endmodule

// File: doc/hash_collector.md
HASH_COLLECTOR -- requirements
Module: hash_collector

Interface
REQ-001 The block SHALL have these ports: clk  in  1  clock; all state changes on the rising edge.
REQ-002 The block SHALL have these ports: rst  in  1  reset; synchronous, active-high.
REQ-003 The block SHALL have these ports: data_in  in  32  hash word from the datapath, qualified by data_out_valid.
REQ-004 The block SHALL have these ports: data_out_valid  in  1  control-unit strobe; high for 4 consecutive cycles, words A,B,C,D in that order.
REQ-005 The block SHALL have these ports: expected  in  128  reference digest for comparison; sampled at capture completion.
REQ-006 The block SHALL have these ports: byte_ready  in  1  consumer accepts byte_out when high with byte_valid.
REQ-007 The block SHALL have these ports: clr_err  in  1  clears sticky error flags.
REQ-008 The block SHALL have these ports: digest  out  128  assembled digest; digest[31:0]=A, [63:32]=B, [95:64]=C, [127:96]=D.
REQ-009 The block SHALL have these ports: digest_valid  out  1  digest complete and not yet fully streamed.
REQ-010 The block SHALL have these ports: match  out  1  digest equals expected; meaningful only while digest_valid.
REQ-011 The block SHALL have these ports: byte_out  out  8  current output byte; byte_valid  out  1  byte_out valid.
REQ-012 The block SHALL have these ports: busy  out  1  high in CAP or STREAM; err_short, err_overflow  out  1 each  sticky error flags.

Function
REQ-013 FSM states SHALL be IDLE, CAP, STREAM; a 2-bit word counter wcnt and a 4-bit byte counter bcnt SHALL exist.
REQ-014 IDLE: when data_out_valid=1, capture data_in into word 0, set wcnt=1, go to CAP.
REQ-015 CAP: each cycle with data_out_valid=1 SHALL write data_in into word wcnt and increment wcnt; the write at wcnt=3 SHALL complete capture and go to STREAM next cycle.
REQ-016 Capture completion SHALL register match=(assembled digest==expected) in the same edge that enters STREAM.
REQ-017 Latency: digest_valid and byte_valid SHALL assert the cycle after the 4th word is sampled.
REQ-018 CAP with data_out_valid=0 (burst of 1-3 words) SHALL set err_short, return to IDLE, and leave digest_valid low.
REQ-019 STREAM: byte_out SHALL equal digest[8*bcnt+7 : 8*bcnt], bcnt starting at 0 (digest[7:0] first).
REQ-020 A byte transfer SHALL occur on any cycle with byte_valid=1 and byte_ready=1; bcnt increments by 1 per transfer, no change otherwise.
REQ-021 The transfer at bcnt=15 SHALL return the FSM to IDLE; digest_valid and byte_valid SHALL be low the following cycle; bcnt wraps to 0.
REQ-022 data_out_valid=1 during STREAM SHALL be ignored for data, SHALL set err_overflow, and SHALL not alter digest, match or bcnt.
REQ-023 digest register SHALL hold its value after STREAM ends until the next capture overwrites it word by word.
REQ-024 clr_err=1 SHALL clear both error flags next cycle; an error event in the same cycle SHALL take priority (flag stays 1).
REQ-025 data_out_valid in the same cycle the last byte is accepted SHALL set err_overflow and SHALL NOT start a new capture.

Reset
REQ-026 rst=1 SHALL force state=IDLE, wcnt=0, bcnt=0, digest=0, match=0, digest_valid=0, byte_valid=0, busy=0, err_short=0, err_overflow=0, byte_out=0.
REQ-027 rst asserted mid-CAP or mid-STREAM SHALL abandon the operation with no error flagged; rst SHALL override every other input.

Structure
REQ-028 The shared hash package SHALL hold the state enum, WORDS=4, BYTES=16, and the 32-bit word typedef.
REQ-029 The byte serializer (bcnt, byte mux, handshake) SHALL be the sub-module hash_byte_ser; all other logic SHALL be in hash_collector.

Verification
REQ-030 The bench SHALL drive 4 words 0x67452301,0xEFCDAB89,0x98BADCFE,0x10325476 with expected equal to their concatenation, then check: digest_valid=1 and match=1 one cycle after the last word.
REQ-031 The bench SHALL hold byte_ready=1 after the normal capture and check: bytes 0x01,0x23,0x45,0x67,0x89,...,0x10 over 16 consecutive cycles, digest_valid=0 on cycle 17.
REQ-032 The bench SHALL toggle byte_ready 1,0,1,0 during STREAM and check: no byte is skipped or repeated, and bcnt advances only on handshake cycles.
REQ-033 The bench SHALL drive a 2-word burst and check: err_short=1, state returns to IDLE, and digest_valid stays 0; a subsequent clr_err SHALL clear err_short.
REQ-034 The bench SHALL drive a new 4-word burst during STREAM and check: err_overflow=1 and digest/byte sequence unchanged; after STREAM completes, the block returns to IDLE.
REQ-035 The bench SHALL assert rst at byte 7 of STREAM and check: all outputs 0 next cycle, and a fresh burst afterwards produces a correct digest.
